// File: rtl/sysid_regs_pkg.sv
// Shared register-map constants and helpers for the system-ID slave.
package sysid_regs_pkg;

  localparam logic [31:0] OFF_ID        = 32'd0;
  localparam logic [31:0] OFF_TIMESTAMP = 32'd1;
  localparam logic [31:0] OFF_SCRATCH   = 32'd2;
  localparam logic [31:0] OFF_UPTIME_LO = 32'd3;
  localparam logic [31:0] OFF_UPTIME_HI = 32'd4;
  localparam logic [31:0] OFF_CAPS      = 32'd5;
  localparam logic [31:0] OFF_USER0     = 32'd6;

  localparam logic [15:0] CAPS_VERSION  = 16'h0002;
  localparam int          MAX_USER      = 16;

  // Words are packed little-end first: word i lives at bits [32i+31:32i].
  function automatic logic [31:0] user_word(input logic [MAX_USER*32-1:0] words,
                                            input int idx);
    return words[idx*32 +: 32];
  endfunction

endpackage

// File: rtl/sysid_read_pipe.sv
// Fixed-latency valid/data delay line for read responses.
module sysid_read_pipe #(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [W-1:0]       dat_q [LATENCY];
  logic [W-1:0]       dat_d [LATENCY];

  // Data is zeroed on entry when not valid, so the output is 0 whenever out_valid is low.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    dat_d[0] = in_valid ? in_data : '0;
    for (int s = 1; s < LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = dat_q[s-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int s = 0; s < LATENCY; s++) dat_q[s] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < LATENCY; s++) dat_q[s] <= dat_d[s];
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/sysid_regs.sv
// System-ID Avalon-MM slave: build ID, timestamp, scratch, 64-bit uptime
// with coherent hi/lo readout, capability word and user constants.
module sysid_regs
  import sysid_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          NUM_USER     = 4,
  parameter logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] USER_WORDS = '0,
  parameter int          READ_LATENCY = 1,
  parameter int          ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [MAX_USER*32-1:0] USER_PAD  = (MAX_USER*32)'(USER_WORDS);
  localparam logic [31:0]            NUM_USER_W = 32'(NUM_USER);
  localparam logic [31:0]            CAPS_WORD  =
    {CAPS_VERSION, 8'(READ_LATENCY), 8'(NUM_USER)};

  logic [31:0] scratch_q, scratch_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] addr_ext;
  logic [31:0] rd_data;
  logic        wr_scratch, clr_cnt, rd_lo;

  assign addr_ext   = 32'(address);
  assign wr_scratch = write && (addr_ext == OFF_SCRATCH);
  assign clr_cnt    = write && (addr_ext == OFF_UPTIME_LO) && (|byteenable);
  assign rd_lo      = read  && (addr_ext == OFF_UPTIME_LO);

  // Read mux samples current state, so a same-cycle write is seen only by later reads.
  always_comb begin
    rd_data = '0;
    case (addr_ext)
      OFF_ID:        rd_data = ID_VALUE;
      OFF_TIMESTAMP: rd_data = TIMESTAMP;
      OFF_SCRATCH:   rd_data = scratch_q;
      OFF_UPTIME_LO: rd_data = cnt_q[31:0];
      OFF_UPTIME_HI: rd_data = hi_shadow_q;
      OFF_CAPS:      rd_data = CAPS_WORD;
      default: begin
        if (addr_ext >= OFF_USER0 && addr_ext < OFF_USER0 + NUM_USER_W)
          rd_data = user_word(USER_PAD, int'(addr_ext - OFF_USER0));
      end
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    for (int k = 0; k < 4; k++) begin
      if (wr_scratch && byteenable[k])
        scratch_d[8*k +: 8] = writedata[8*k +: 8];
    end
    cnt_d       = clr_cnt ? 64'd0 : cnt_q + 64'd1;
    hi_shadow_d = rd_lo ? cnt_q[63:32] : hi_shadow_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scratch_q   <= '0;
      cnt_q       <= '0;
      hi_shadow_q <= '0;
    end else begin
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  sysid_read_pipe #(
    .LATENCY (READ_LATENCY),
    .W       (32)
  ) u_read_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (read),
    .in_data   (rd_data),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_sysid_regs.sv
// Directed bench: three instances (latency 1, 2, 3) share one bus and one expected-response list.
module tb_sysid_regs;

  localparam logic [127:0] USER_W = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        rdv   [3];
  logic [31:0] rdata [3];

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] exp_data [0:255];
  int          exp_cyc  [0:255];
  bit          exp_caps [0:255];
  int          n_issued = 0;
  int          head [3] = '{0, 0, 0};
  int          flush_base = 0;
  int          flush_cyc = 0;
  bit          done_req = 1'b0;
  bit          done = 1'b0;

  logic [31:0] caps_exp [3] = '{32'h0002_0104, 32'h0002_0204, 32'h0002_0304};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      sysid_regs #(
        .ID_VALUE     (32'hCAFE_0001),
        .TIMESTAMP    (32'h4DD5_0000),
        .NUM_USER     (4),
        .USER_WORDS   (USER_W),
        .READ_LATENCY (gi + 1),
        .ADDR_W       (4)
      ) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (rdata[gi]),
        .readdatavalid (rdv[gi])
      );
    end
  endgenerate

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every cycle each instance must either deliver the next due read or stay idle with zero data.
  always @(negedge clock) begin
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        while (head[i] < flush_base && head[i] < n_issued && exp_cyc[head[i]] + i + 1 > flush_cyc)
          head[i]++;
        if (head[i] < n_issued && exp_cyc[head[i]] + i + 1 == cyc) begin
          check_vec($sformatf("L%0d rd#%0d valid", i + 1, head[i]), 32'(rdv[i]), 32'd1);
          check_vec($sformatf("L%0d rd#%0d data", i + 1, head[i]), rdata[i],
                    exp_caps[head[i]] ? caps_exp[i] : exp_data[head[i]]);
          $display("rsp L%0d rd#%0d cyc=%0d data=%h", i + 1, head[i], cyc, rdata[i]);
          head[i]++;
        end else begin
          check_vec($sformatf("L%0d idle valid cyc%0d", i + 1, cyc), 32'(rdv[i]), 32'd0);
          check_vec($sformatf("L%0d idle data cyc%0d", i + 1, cyc), rdata[i], 32'd0);
        end
      end
      if (done_req && !done) begin
        for (int i = 0; i < 3; i++)
          check_vec($sformatf("L%0d drained", i + 1), 32'(head[i]), 32'(n_issued));
        done = 1'b1;
      end
    end
  end

  task automatic bus(input logic rd, input logic wr, input logic [3:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] exp, input bit is_caps);
    @(posedge clock);
    #2;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    if (rd) begin
      exp_data[n_issued] = exp;
      exp_cyc[n_issued]  = cyc;
      exp_caps[n_issued] = is_caps;
      n_issued++;
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    bus(1'b1, 1'b0, a, 32'd0, 4'd0, exp, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
    bus(1'b0, 1'b1, a, wd, be, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clock);
    #2;
    reset_n = 1'b0; read = 1'b0; write = 1'b0;
    flush_base = n_issued;
    flush_cyc  = cyc;
    repeat (n) @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    // ID / timestamp, isolated ID read, back-to-back including CAPS
    rd(4'd0, 32'hCAFE_0001);
    rd(4'd1, 32'h4DD5_0000);
    idle(4);
    rd(4'd0, 32'hCAFE_0001);
    idle(4);
    rd(4'd0, 32'hCAFE_0001);
    rd(4'd1, 32'h4DD5_0000);
    bus(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 32'd0, 1'b1);
    idle(4);
    // Scratch byte lanes and same-cycle read/write
    rd(4'd2, 32'h0000_0000);
    wr(4'd2, 32'hAABB_CCDD, 4'b1111);
    wr(4'd2, 32'h1122_3344, 4'b0101);
    rd(4'd2, 32'hAA22_CC44);
    wr(4'd2, 32'hFFFF_FFFF, 4'b0000);
    rd(4'd2, 32'hAA22_CC44);
    bus(1'b1, 1'b1, 4'd2, 32'h5555_6666, 4'b1111, 32'hAA22_CC44, 1'b0);
    rd(4'd2, 32'h5555_6666);
    // Unmapped, read-only and user offsets
    rd(4'd10, 32'h0000_0000);
    wr(4'd10, 32'hFFFF_FFFF, 4'b1111);
    wr(4'd0, 32'h1234_5678, 4'b1111);
    rd(4'd2, 32'h5555_6666);
    rd(4'd0, 32'hCAFE_0001);
    rd(4'd8, 32'h3333_3333);
    rd(4'd6, 32'h1111_1111);
    rd(4'd9, 32'h4444_4444);
    idle(4);
    // Coherent hi/lo: LO read under a forced counter value, HI read later
    rd(4'd3, 32'hFFFF_FFFF);
    force g_dut[0].u_dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
    force g_dut[1].u_dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
    force g_dut[2].u_dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
    idle(1);
    release g_dut[0].u_dut.cnt_q;
    release g_dut[1].u_dut.cnt_q;
    release g_dut[2].u_dut.cnt_q;
    idle(4);
    rd(4'd4, 32'h0000_0001);
    // Uptime clear, then same-cycle read+clear returns the pre-clear value
    wr(4'd3, 32'd0, 4'b0001);
    idle(4);
    rd(4'd3, 32'd4);
    bus(1'b1, 1'b1, 4'd3, 32'd0, 4'b1111, 32'd5, 1'b0);
    rd(4'd3, 32'd0);
    rd(4'd4, 32'd0);
    idle(4);
    // Reset with reads still in flight
    rd(4'd0, 32'hCAFE_0001);
    rd(4'd1, 32'h4DD5_0000);
    do_reset(3);
    rd(4'd3, 32'd1);
    rd(4'd2, 32'h0000_0000);
    rd(4'd4, 32'h0000_0000);
    idle(6);
    done_req = 1'b1;
    repeat (4) @(posedge clock);
    if (!done) begin
      n_bad++;
      $display("FAIL end: got done=0 expected done=1");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
